// File: rtl/ex_stage_pkg.sv
// Shared widths, opcode encodings and the decoded ID->EX bus layout for the
// execute stage of the RV32I pipeline.
package ex_stage_pkg;

  localparam int ID_TO_EX_BUS_WD         = 211;
  localparam int EX_TO_MEM_BUS_WD        = 176;
  localparam int READ_AFTER_WRITE_BUS_WD = 39;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_NONE = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_NONE = 2'b11
  } shift_op_e;

  // Load/store width codes; other codes (unsigned loads) pass through to MEM.
  localparam logic [2:0] LS_B = 3'b000;
  localparam logic [2:0] LS_H = 3'b001;
  localparam logic [2:0] LS_W = 3'b010;

  // Register write-back source select, shared with mem_stage.
  localparam logic [2:0] WDATA_SRC_ALU   = 3'b000;
  localparam logic [2:0] WDATA_SRC_PC4   = 3'b001;
  localparam logic [2:0] WDATA_SRC_SHIFT = 3'b010;
  localparam logic [2:0] WDATA_SRC_LUI   = 3'b011;
  localparam logic [2:0] WDATA_SRC_AUIPC = 3'b100;

  // Decoded instruction as delivered by id_stage, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    alu_op_e     alu_op;
    shift_op_e   shift_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] store_data;
    logic [2:0]  ls_type;
    logic        mem_read;
    logic        mem_write;
    logic        rf_write;
    logic [4:0]  rf_waddr;
    logic [2:0]  rf_wdata_src;
    logic [31:0] lui_wdata;
    logic [31:0] auipc_wdata;
  } id_to_ex_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational integer ALU for the execute stage.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  alu_op_e     alu_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  // Select the arithmetic/logic result; the unused encoding yields zero.
  always_comb begin
    // NOTE: default assigned first so no path leaves result_o unassigned (no latch).
    result_o = '0;
    case (alu_op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'b0, a_i < b_i};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: registers the ID->EX bus, computes ALU/shift/store data,
// issues the data-memory request and exports the forwarding bus to ID.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               mem_allow_in,
  output logic                               ex_allow_in,
  input  logic                               id_to_ex_valid,
  input  logic [ID_TO_EX_BUS_WD-1:0]         id_to_ex_bus,
  output logic                               ex_to_mem_valid,
  output logic [EX_TO_MEM_BUS_WD-1:0]        ex_to_mem_bus,
  output logic [READ_AFTER_WRITE_BUS_WD-1:0] ex_read_after_write_bus,
  output logic [31:0]                        Address,
  output logic                               MemRead,
  output logic                               MemWrite,
  output logic [31:0]                        Write_data,
  output logic [3:0]                         Write_strb,
  input  logic                               Mem_Req_Ready
);

  logic        ex_valid_q;
  id_to_ex_t   id_q;
  logic        req_done_q;
  logic        req_done_d;

  logic        mem_op;
  logic        req_pend;
  logic        req_accept;
  logic        ex_ready_go;
  logic        ex_leave;

  logic [31:0] alu_result;
  logic [31:0] shift_result;
  logic [4:0]  shamt;
  logic [1:0]  byte_off;
  logic [31:0] ex_wdata;

  // Stage valid bit: follows the upstream valid whenever the stage can accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
    end else if (ex_allow_in) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      ex_valid_q <= id_to_ex_valid;
    end
  end

  // Instruction payload register, loaded only on a real transfer.
  always_ff @(posedge clk) begin
    // NOTE: payload is qualified by ex_valid_q, so it needs no reset and stays a plain enable flop.
    if (id_to_ex_valid && ex_allow_in) begin
      id_q <= id_to_ex_bus;
    end
  end

  // Request-accepted flag: remembers an accepted request while the stage is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_done_q <= 1'b0;
    end else begin
      req_done_q <= req_done_d;
    end
  end

  // Next value of the request-accepted flag; leaving has priority over setting.
  always_comb begin
    req_done_d = req_done_q;
    if (ex_leave) begin
      req_done_d = 1'b0;
    end else if (req_accept) begin
      req_done_d = 1'b1;
    end
  end

  // Handshake and memory-request issue. Requests only go out when MEM can
  // take the instruction, which keeps at most one load in flight.
  assign mem_op          = id_q.mem_read | id_q.mem_write;
  assign req_pend        = ex_valid_q && mem_op && !req_done_q && mem_allow_in;
  assign MemRead         = req_pend && id_q.mem_read;
  assign MemWrite        = req_pend && id_q.mem_write;
  assign req_accept      = (MemRead || MemWrite) && Mem_Req_Ready;
  assign ex_ready_go     = !mem_op || req_done_q || (req_pend && Mem_Req_Ready);
  assign ex_to_mem_valid = ex_valid_q && ex_ready_go;
  assign ex_allow_in     = !ex_valid_q || (ex_ready_go && mem_allow_in);
  assign ex_leave        = ex_to_mem_valid && mem_allow_in;

  ex_stage_alu u_alu (
    .alu_op_i (id_q.alu_op),
    .a_i      (id_q.op_a),
    .b_i      (id_q.op_b),
    .result_o (alu_result)
  );

  assign shamt = id_q.op_b[4:0];

  // Barrel shifter on opA by the low five bits of opB.
  always_comb begin
    shift_result = '0;
    case (id_q.shift_op)
      SHIFT_SLL: shift_result = id_q.op_a << shamt;
      SHIFT_SRL: shift_result = id_q.op_a >> shamt;
      SHIFT_SRA: shift_result = $unsigned($signed(id_q.op_a) >>> shamt);
      default:   shift_result = '0;
    endcase
  end

  assign byte_off = alu_result[1:0];
  assign Address  = {alu_result[31:2], 2'b00};

  // Store formatter: replicate data across byte lanes and pick byte enables.
  always_comb begin
    Write_strb = 4'b0000;
    Write_data = id_q.store_data;
    case (id_q.ls_type)
      LS_B: begin
        Write_strb = 4'b0001 << byte_off;
        Write_data = {4{id_q.store_data[7:0]}};
      end
      LS_H: begin
        Write_strb = byte_off[1] ? 4'b1100 : 4'b0011;
        Write_data = {2{id_q.store_data[15:0]}};
      end
      LS_W: begin
        Write_strb = 4'b1111;
        Write_data = id_q.store_data;
      end
      default: begin
        Write_strb = 4'b0000;
        Write_data = id_q.store_data;
      end
    endcase
  end

  // Write-back value visible to ID for forwarding, same selection as MEM.
  always_comb begin
    ex_wdata = '0;
    case (id_q.rf_wdata_src)
      WDATA_SRC_ALU:   ex_wdata = alu_result;
      WDATA_SRC_PC4:   ex_wdata = id_q.pc + 32'd4;
      WDATA_SRC_SHIFT: ex_wdata = shift_result;
      WDATA_SRC_LUI:   ex_wdata = id_q.lui_wdata;
      WDATA_SRC_AUIPC: ex_wdata = id_q.auipc_wdata;
      default:         ex_wdata = '0;
    endcase
  end

  // A load's data only exists after MEM, so it is flagged not-ready here.
  assign ex_read_after_write_bus = {ex_valid_q && id_q.rf_write, !id_q.mem_read,
                                    id_q.rf_waddr, ex_wdata};

  assign ex_to_mem_bus = {id_q.pc, id_q.ls_type, id_q.mem_read, alu_result,
                          shift_result, id_q.rf_write, id_q.rf_waddr,
                          id_q.rf_wdata_src, id_q.lui_wdata, id_q.auipc_wdata,
                          3'b000};

endmodule
